// File: rtl/hazard_controller.sv
// hazard_controller: detects the pipeline hazards that forwarding cannot cover
// (load-use, HI/LO interlock against the iterative multiply/divide unit) and
// the taken-branch flush. It drives the fetch/decode enables, the ID/EX bubble
// and flush controls, and keeps a saturating count of stall cycles.
module hazard_controller #(
    parameter int unsigned LU_CYCLES  = 1,
    parameter int unsigned MD_LATENCY = 32
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        MemRead_EX,
    input  logic [4:0]  RT_EX,
    input  logic [4:0]  RS_ID,
    input  logic [4:0]  RT_ID,
    input  logic        UsesRT_ID,
    input  logic        MulDiv_ID,
    input  logic        ReadsHiLo_ID,
    input  logic        Branch_Taken_EX,
    output logic        PCWrite,
    output logic        IFIDWrite,
    output logic        IDEX_Bubble,
    output logic        IFID_Flush,
    output logic        IDEX_Flush,
    output logic        MD_Start,
    output logic        MD_Busy,
    output logic [15:0] StallCount
);

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        LU_WAIT = 1'b1
    } state_t;

    // Reload values; a single-cycle load-use stall never leaves RUN.
    localparam logic [3:0] LU_LOAD  = 4'(LU_CYCLES - 1);
    localparam logic [5:0] MD_LOAD  = 6'(MD_LATENCY);
    localparam bit         LU_MULTI = (LU_CYCLES > 1);

    state_t      state_r, state_n;
    logic [3:0]  lu_cnt_r, lu_cnt_n;
    logic [5:0]  md_cnt_r, md_cnt_n;
    logic [15:0] stall_count_r, stall_count_n;

    logic lu_hit_s, md_busy_s, md_hit_s, stall_s, md_start_s;

    // Hazard detection, stall decision and multiply/divide start qualification.
    always_comb begin
        lu_hit_s   = MemRead_EX && (RT_EX != 5'd0) &&
                     ((RT_EX == RS_ID) || (UsesRT_ID && (RT_EX == RT_ID)));
        md_busy_s  = (md_cnt_r != 6'd0);
        md_hit_s   = (MulDiv_ID || ReadsHiLo_ID) && md_busy_s;
        // The branch flush wins: the instruction in ID is being discarded anyway.
        stall_s    = !Branch_Taken_EX &&
                     ((state_r == LU_WAIT) || ((state_r == RUN) && lu_hit_s) || md_hit_s);
        md_start_s = MulDiv_ID && !stall_s && !Branch_Taken_EX;
    end

    // Outputs are held at their idle values while reset is asserted.
    assign PCWrite     = !Reset_n || !stall_s;
    assign IFIDWrite   = !Reset_n || !stall_s;
    assign IDEX_Bubble = Reset_n && stall_s;
    assign IFID_Flush  = Reset_n && Branch_Taken_EX;
    assign IDEX_Flush  = Reset_n && Branch_Taken_EX;
    assign MD_Start    = Reset_n && md_start_s;
    assign MD_Busy     = Reset_n && md_busy_s;
    assign StallCount  = stall_count_r;

    // Load-use FSM next state: hold the pipeline for the remaining stall cycles.
    always_comb begin
        state_n  = state_r;
        lu_cnt_n = lu_cnt_r;
        case (state_r)
            RUN: begin
                if (lu_hit_s && !Branch_Taken_EX && LU_MULTI) begin
                    state_n  = LU_WAIT;
                    lu_cnt_n = LU_LOAD;
                end else begin
                    state_n  = RUN;
                    lu_cnt_n = 4'd0;
                end
            end
            LU_WAIT: begin
                if (Branch_Taken_EX || (lu_cnt_r <= 4'd1)) begin
                    state_n  = RUN;
                    lu_cnt_n = 4'd0;
                end else begin
                    state_n  = LU_WAIT;
                    lu_cnt_n = lu_cnt_r - 4'd1;
                end
            end
            default: begin
                state_n  = RUN;
                lu_cnt_n = 4'd0;
            end
        endcase
    end

    // Multiply/divide countdown and saturating stall counter next values.
    // A branch never clears md_cnt: the in-flight operation predates the branch.
    always_comb begin
        md_cnt_n      = md_cnt_r;
        stall_count_n = stall_count_r;
        if (md_start_s) begin
            md_cnt_n = MD_LOAD;
        end else if (md_busy_s) begin
            md_cnt_n = md_cnt_r - 6'd1;
        end else begin
            md_cnt_n = 6'd0;
        end
        if (stall_s && (stall_count_r != 16'hFFFF)) begin
            stall_count_n = stall_count_r + 16'd1;
        end else begin
            stall_count_n = stall_count_r;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r       <= RUN;
            lu_cnt_r      <= 4'd0;
            md_cnt_r      <= 6'd0;
            stall_count_r <= 16'd0;
        end else begin
            state_r       <= state_n;
            lu_cnt_r      <= lu_cnt_n;
            md_cnt_r      <= md_cnt_n;
            stall_count_r <= stall_count_n;
        end
    end

endmodule

// File: tb/tb_hazard_controller.sv
// Testbench for hazard_controller: two instances (LU_CYCLES=3 and 1, both with
// MD_LATENCY=4) share one stimulus stream. A cycle-time reference model
// (stall end cycle, multiply start cycle, saturating count) predicts outputs.
module tb_hazard_controller;

    localparam int MD_LAT = 4;

    logic       Clk, Reset_n;
    logic       MemRead_EX, UsesRT_ID, MulDiv_ID, ReadsHiLo_ID, Branch_Taken_EX;
    logic [4:0] RT_EX, RS_ID, RT_ID;

    logic [6:0]  flags_o [2];
    logic [15:0] cnt_o   [2];

    int n_vec = 0;
    int n_err = 0;

    // Reference model state, per instance.
    int lu_len   [2] = '{3, 1};
    int lu_end   [2] = '{-1, -1};
    int md_start [2] = '{-1000, -1000};
    int cnt      [2] = '{0, 0};
    int cyc = 0;

    logic a_pc, a_ifid, a_bub, a_ff, a_df, a_st, a_busy;
    logic b_pc, b_ifid, b_bub, b_ff, b_df, b_st, b_busy;
    logic [15:0] a_cnt, b_cnt;

    hazard_controller #(.LU_CYCLES(3), .MD_LATENCY(MD_LAT)) dut_a (
        .Clk(Clk), .Reset_n(Reset_n), .MemRead_EX(MemRead_EX), .RT_EX(RT_EX),
        .RS_ID(RS_ID), .RT_ID(RT_ID), .UsesRT_ID(UsesRT_ID), .MulDiv_ID(MulDiv_ID),
        .ReadsHiLo_ID(ReadsHiLo_ID), .Branch_Taken_EX(Branch_Taken_EX),
        .PCWrite(a_pc), .IFIDWrite(a_ifid), .IDEX_Bubble(a_bub), .IFID_Flush(a_ff),
        .IDEX_Flush(a_df), .MD_Start(a_st), .MD_Busy(a_busy), .StallCount(a_cnt));

    hazard_controller #(.LU_CYCLES(1), .MD_LATENCY(MD_LAT)) dut_b (
        .Clk(Clk), .Reset_n(Reset_n), .MemRead_EX(MemRead_EX), .RT_EX(RT_EX),
        .RS_ID(RS_ID), .RT_ID(RT_ID), .UsesRT_ID(UsesRT_ID), .MulDiv_ID(MulDiv_ID),
        .ReadsHiLo_ID(ReadsHiLo_ID), .Branch_Taken_EX(Branch_Taken_EX),
        .PCWrite(b_pc), .IFIDWrite(b_ifid), .IDEX_Bubble(b_bub), .IFID_Flush(b_ff),
        .IDEX_Flush(b_df), .MD_Start(b_st), .MD_Busy(b_busy), .StallCount(b_cnt));

    assign flags_o[0] = {a_pc, a_ifid, a_bub, a_ff, a_df, a_st, a_busy};
    assign flags_o[1] = {b_pc, b_ifid, b_bub, b_ff, b_df, b_st, b_busy};
    assign cnt_o[0]   = a_cnt;
    assign cnt_o[1]   = b_cnt;

    // Free-running clock.
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic drive(input logic mr, input int rtex, input int rs, input int rt,
                         input logic ur, input logic md, input logic hl, input logic br);
        MemRead_EX      = mr;
        RT_EX           = 5'(rtex);
        RS_ID           = 5'(rs);
        RT_ID           = 5'(rt);
        UsesRT_ID       = ur;
        MulDiv_ID       = md;
        ReadsHiLo_ID    = hl;
        Branch_Taken_EX = br;
    endtask

    // Check both instances against the model for the current cycle, then
    // advance the model across the rising edge. Called just after a falling edge.
    task automatic step(input string tag);
        logic [6:0] exp_f [2];
        logic [15:0] exp_c [2];
        int  nxt_end [2];
        int  nxt_md  [2];
        int  nxt_cnt [2];
        logic hit, busy, wait_lu, stall, start;
        #2;
        hit = MemRead_EX && (RT_EX != 5'd0) &&
              ((RT_EX == RS_ID) || (UsesRT_ID && (RT_EX == RT_ID)));
        for (int k = 0; k < 2; k++) begin
            if (!Reset_n) begin
                exp_f[k]   = 7'b1100000;
                exp_c[k]   = 16'd0;
                nxt_end[k] = -1;
                nxt_md[k]  = -1000;
                nxt_cnt[k] = 0;
            end else begin
                busy    = (cyc > md_start[k]) && (cyc <= md_start[k] + MD_LAT);
                wait_lu = (cyc <= lu_end[k]);
                stall   = !Branch_Taken_EX &&
                          (wait_lu || hit || ((MulDiv_ID || ReadsHiLo_ID) && busy));
                start   = MulDiv_ID && !stall && !Branch_Taken_EX;
                exp_f[k] = {!stall, !stall, stall, Branch_Taken_EX, Branch_Taken_EX, start, busy};
                exp_c[k] = 16'(cnt[k]);
                nxt_end[k] = lu_end[k];
                if (Branch_Taken_EX)      nxt_end[k] = -1;
                else if (!wait_lu && hit) nxt_end[k] = cyc + lu_len[k] - 1;
                nxt_md[k]  = start ? cyc : md_start[k];
                nxt_cnt[k] = (stall && cnt[k] < 65535) ? cnt[k] + 1 : cnt[k];
            end
            n_vec++;
            assert (flags_o[k] === exp_f[k]) else begin
                n_err++;
                $error("FAIL %s_flags[%0d] cyc=%0d observed=%b expected=%b", tag, k, cyc, flags_o[k], exp_f[k]);
            end
            n_vec++;
            assert (cnt_o[k] === exp_c[k]) else begin
                n_err++;
                $error("FAIL %s_count[%0d] cyc=%0d observed=%h expected=%h", tag, k, cyc, cnt_o[k], exp_c[k]);
            end
        end
        @(posedge Clk);
        for (int k = 0; k < 2; k++) begin
            lu_end[k]   = nxt_end[k];
            md_start[k] = nxt_md[k];
            cnt[k]      = nxt_cnt[k];
        end
        cyc++;
        @(negedge Clk);
    endtask

    initial begin
        Reset_n = 1'b0;
        drive(1'b1, 5, 5, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge Clk);
        @(negedge Clk);

        // Reset forces idle outputs despite a live load-use hazard.
        step("reset_hazard");
        Reset_n = 1'b1;
        step("release");
        step("release2");

        // lw $8 / add rs=$8 for one cycle, then clear.
        drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (4) step("idle");
        drive(1'b1, 8, 8, 3, 1'b0, 1'b0, 1'b0, 1'b0);
        step("lu_hit");
        drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (4) step("lu_after");
        // Load to $0 never stalls.
        drive(1'b1, 0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("lu_r0");
        // rt compared only when UsesRT_ID=1.
        drive(1'b1, 9, 1, 9, 1'b0, 1'b0, 1'b0, 1'b0);
        step("rt_unused");
        drive(1'b1, 9, 1, 9, 1'b1, 1'b0, 1'b0, 1'b0);
        step("rt_used");
        drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (4) step("idle");

        // Load-use cut short by a branch in the 2nd stall cycle.
        drive(1'b1, 8, 8, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("lu_br_hit");
        drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        step("lu_br_flush");
        drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) step("lu_br_after");

        // mult at t, mflo t+1..t+5.
        drive(1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        step("md_start");
        drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (5) step("md_mflo");
        drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) step("idle");
        // mult with a taken branch: no start.
        drive(1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b1);
        step("md_branch");
        drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        step("md_branch_after");
        // mult together with a load-use hazard, then alone.
        drive(1'b1, 4, 4, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        step("md_lu_hit");
        drive(1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (8) step("md_lu_after");

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            Reset_n = ($urandom_range(0, 199) != 0);
            drive(($urandom_range(0, 2) == 0), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), 1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 4) == 0), ($urandom_range(0, 7) == 0));
            step("rand");
        end
        Reset_n = 1'b1;

        // Continuous hazard long enough to saturate the stall counter.
        drive(1'b1, 7, 7, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 65540; i++) step("saturate");
        drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (4) step("sat_hold");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_controller.md
# hazard_controller

Pipeline hazard controller for the five-stage MIPS datapath. It sits beside the forwarding logic and handles the hazards forwarding cannot resolve:

- load-use stalls, extendable for slow data memory;
- HI/LO interlock against an iterative multiply/divide unit;
- IF/ID and ID/EX flushes on a taken branch resolved in EX.

It drives the PC/IF-ID write enables, the ID/EX bubble mux and the flush controls, and keeps a saturating stall-cycle counter.

## Interface
- LU_CYCLES, 1, stall cycles per load-use hazard (1..15)
- MD_LATENCY, 32, cycles from multiply/divide start until HI/LO is valid (2..63)
- Clk  in  1  rising-edge clock
- Reset_n  in  1  asynchronous, active-low reset
- MemRead_EX  in  1  instruction in EX is a load
- RT_EX  in  5  load destination register in EX
- RS_ID  in  5  rs of the instruction in ID
- RT_ID  in  5  rt of the instruction in ID
- UsesRT_ID  in  1  instruction in ID reads rt as a source
- MulDiv_ID  in  1  instruction in ID is mult/multu/div/divu
- ReadsHiLo_ID  in  1  instruction in ID is mfhi/mflo
- Branch_Taken_EX  in  1  branch/jump in EX resolved taken this cycle
- PCWrite  out  1  PC update enable
- IFIDWrite  out  1  IF/ID register enable
- IDEX_Bubble  out  1  zero the control fields entering ID/EX
- IFID_Flush  out  1  clear IF/ID
- IDEX_Flush  out  1  clear ID/EX
- MD_Start  out  1  one-cycle start pulse to the multiply/divide unit
- MD_Busy  out  1  multiply/divide in progress
- StallCount  out  16  saturating count of stall cycles

## Operation
- **Internal state:**
  - FSM: RUN, LU_WAIT.
  - lu_cnt: 4 bits.
  - md_cnt: 6 bits.
  - StallCount: 16-bit register.
- **lu_hit** = MemRead_EX && RT_EX!=0 && (RT_EX==RS_ID || (UsesRT_ID && RT_EX==RT_ID)).
- **md_hit** = (MulDiv_ID || ReadsHiLo_ID) && md_cnt!=0.
- **Stall** = !Branch_Taken_EX && (state==LU_WAIT || (state==RUN && lu_hit) || md_hit).
  - Priority: branch flush > load-use stall > multiply/divide stall.
- **Outputs (combinational):**
  - PCWrite = IFIDWrite = !Stall.
  - IDEX_Bubble = Stall.
  - IFID_Flush = IDEX_Flush = Branch_Taken_EX.
  - MD_Start = MulDiv_ID && !Stall && !Branch_Taken_EX.
  - MD_Busy = md_cnt!=0.
- **RUN:**
  - If lu_hit && !Branch_Taken_EX && LU_CYCLES>1: go to LU_WAIT, lu_cnt <= LU_CYCLES-1.
  - Otherwise stay in RUN.
- **LU_WAIT:**
  - Stall is asserted regardless of lu_hit.
  - lu_cnt decrements each cycle. When lu_cnt==1, return to RUN next edge.
  - Branch_Taken_EX: return to RUN immediately, lu_cnt <= 0.
- **md_cnt:**
  - On MD_Start: load MD_LATENCY.
  - Else if nonzero: decrement.
  - Branch flush does not touch md_cnt; the in-flight operation is older than the branch.
- **StallCount:** +1 on every cycle with Stall=1; holds at 16'hFFFF.

## Timing
- **Reset (Reset_n low), asynchronous:**
  - State RUN, lu_cnt=0, md_cnt=0, StallCount=0.
  - Outputs forced: PCWrite=1, IFIDWrite=1, IDEX_Bubble=0, IFID_Flush=0, IDEX_Flush=0, MD_Start=0, MD_Busy=0.
  - Release is synchronous to the next Clk edge. A reset mid-stall or mid-multiply abandons that operation.
- **Load-use stall:** asserted in the same cycle lu_hit is seen. Total stall = LU_CYCLES consecutive cycles.
- **Multiply/divide:**
  - MD_Start in cycle t gives MD_Busy=1 in cycles t+1..t+MD_LATENCY.
  - A dependent mfhi/mflo or second mult/div stalls through t+MD_LATENCY and advances in t+MD_LATENCY+1.
- **Flushes** are 0-latency with Branch_Taken_EX and last exactly the cycles it is high.
- **Simultaneous events:**
  - lu_hit and md_hit together: single stall. The stall lasts until both clear.
  - MulDiv_ID with lu_hit: no MD_Start until the stall ends.
  - md_cnt==1 with mfhi in ID: stall that cycle; proceed the next.
- **Register rules:**
  - A load to $0 never stalls.
  - rt comparison only counts when UsesRT_ID=1.

## Test plan
- Reset low with MemRead_EX=1, RT_EX=5, RS_ID=5 -> PCWrite=1, IDEX_Bubble=0, StallCount=0; after release, first edge gives StallCount=1.
- LU_CYCLES=1; lw $8 in EX with add rs=$8 in ID -> one cycle PCWrite=0, IDEX_Bubble=1, then resume. Same case with RT_EX=0 -> no stall.
- LU_CYCLES=3; hazard present 1 cycle only -> exactly 3 stall cycles. Branch_Taken_EX in the 2nd stall cycle -> both flushes =1, stall drops that cycle, state RUN.
- MD_LATENCY=4; mult in ID at t -> MD_Start=1 at t, MD_Busy t+1..t+4. mflo in ID at t+1 -> stalled t+1..t+4, PCWrite=1 at t+5.
- mult in ID with Branch_Taken_EX=1 -> MD_Start=0, md_cnt stays 0, both flushes =1.
- Force 65540 stall cycles -> StallCount holds at 16'hFFFF.
